// File: rtl/exu_posu_wb_ctl_pkg.sv
// exu_posu_wb_ctl_pkg: shared veer_types package with the writeback entry type and the posit NaR encoding.
package veer_types;
  localparam logic [31:0] POSIT_NAR = 32'h8000_0000;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        done;
  } posu_wb_entry_t;
endpackage

// File: rtl/exu_posu_wb_ctl.sv
// exu_posu_wb_ctl: in-order posit result writeback queue with flush drop tracking.
// Optional combinational finish-to-writeback bypass under RV_POSU_WB_BYPASS_EN.
module exu_posu_wb_ctl
  import veer_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_stall,
  input  logic        posu_finish,
  input  logic [31:0] posu_out,
  input  logic        flush,
  input  logic        wb_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_nar
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  posu_wb_entry_t ent_q [DEPTH];
  posu_wb_entry_t ent_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, fill_ptr_q, fill_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic drop_pend_q, drop_pend_d;
  logic pend, alloc, fill, retire, byp, reg_valid;
  assign pend        = fill_ptr_q != wr_ptr_q;
  assign issue_stall = count_q == FULL;
  assign reg_valid   = ent_q[rd_ptr_q].done;
`ifdef RV_POSU_WB_BYPASS_EN
  assign byp = posu_finish & pend & ~drop_pend_q & ~flush & (count_q == CW'(1));
`else
  assign byp = 1'b0;
`endif
  assign wb_valid = reg_valid | byp;
  assign wb_rd    = wb_valid ? ent_q[rd_ptr_q].rd : '0;
  assign wb_data  = byp ? posu_out : (wb_valid ? ent_q[rd_ptr_q].data : '0);
  assign wb_nar   = wb_valid & (wb_data == POSIT_NAR);
  assign alloc    = issue_valid & ~issue_stall;
  assign retire   = wb_valid & wb_ready;
  assign fill     = posu_finish & pend & ~drop_pend_q;
  always_comb begin
    ent_d       = ent_q;
    wr_ptr_d    = wr_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    drop_pend_d = drop_pend_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].done = 1'b0;
      wr_ptr_d    = '0;
      fill_ptr_d  = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      // an op still in flight after the flush must have its finish swallowed
      drop_pend_d = pend ? (~posu_finish | drop_pend_q) : (drop_pend_q & ~posu_finish);
    end else begin
      if (alloc) begin
        ent_d[wr_ptr_q].rd   = issue_rd;
        ent_d[wr_ptr_q].done = 1'b0;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (fill) begin
        if (!(byp & wb_ready)) begin
          ent_d[fill_ptr_q].data = posu_out;
          ent_d[fill_ptr_q].done = 1'b1;
        end
        fill_ptr_d = fill_ptr_q + PW'(1);
      end
      if (retire) begin
        ent_d[rd_ptr_q].done = 1'b0;
        rd_ptr_d             = rd_ptr_q + PW'(1);
      end
      if (drop_pend_q & posu_finish) drop_pend_d = 1'b0;
      count_d = count_q + CW'(alloc) - CW'(retire);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      wr_ptr_q    <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      drop_pend_q <= 1'b0;
    end else begin
      ent_q       <= ent_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      drop_pend_q <= drop_pend_d;
    end
  end
endmodule
